// File: rtl/log_sub_unit.sv
// Registered -ln(1 - 2^-i) lookup followed by a wrapping fixed-point subtract.
// Signed flags describe a - log_val directly; log_val is one cycle behind i.
module log_sub_unit #(
    parameter int unsigned XLEN_PIXEL = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                i,
    input  logic [2*XLEN_PIXEL-1:0]   a,
    output logic [2*XLEN_PIXEL-1:0]   log_val,
    output logic [2*XLEN_PIXEL-1:0]   diff,
    output logic                      neg,
    output logic                      ovf
);

    localparam int unsigned W = 2 * XLEN_PIXEL;

    // Evaluated only at elaboration; a real-to-integer cast rounds ties away from zero.
    function automatic logic [W-1:0] rom_entry(input int idx);
        real          v;
        real          x;
        real          scaled;
        real          max_r;
        longint       r;
        logic [W-1:0] sat;
        sat   = {1'b0, {(W-1){1'b1}}};
        max_r = (2.0 ** (W - 1)) - 1.0;
        case (idx)
            1:       v = 0.6931471805599453;
            2:       v = 0.2876820724517809;
            3:       v = 0.1335313926245226;
            4:       v = 0.0645385211375712;
            5:       v = 0.0317486983145803;
            6:       v = 0.0157483569681392;
            7:       v = 0.0078431774610259;
            8:       v = 0.0039138993211363;
            9:       v = 0.0019550348358033;
            10:      v = 0.0009770396132999;
            default: begin
                x = 1.0 / (2.0 ** idx);
                v = x + (x * x) / 2.0 + (x * x * x) / 3.0 + (x * x * x * x) / 4.0;
            end
        endcase
        scaled = v * (2.0 ** XLEN_PIXEL);
        if (idx == 0 || scaled >= max_r) begin
            return sat;
        end
        r = longint'(scaled);
        return r[W-1:0];
    endfunction

    logic [W-1:0] rom [32];

    for (genvar g = 0; g < 32; g++) begin : g_rom
        localparam logic [W-1:0] Entry = rom_entry(g);
        assign rom[g] = Entry;
    end

    logic [W-1:0] log_val_d;
    logic [W-1:0] log_val_q;

    always_comb begin
        log_val_d = rom[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_val_q <= '0;
        end else begin
            log_val_q <= log_val_d;
        end
    end

    always_comb begin
        diff = a - log_val_q;
        neg  = diff[W-1];
        ovf  = (a[W-1] ^ log_val_q[W-1]) & (diff[W-1] ^ a[W-1]);
    end

    assign log_val = log_val_q;

endmodule

// File: tb/tb_log_sub_unit.sv
// Directed-vector bench for log_sub_unit at XLEN_PIXEL = 8.
module tb_log_sub_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  i;
    logic [15:0] a;
    logic [15:0] log_val;
    logic [15:0] diff;
    logic        neg;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    log_sub_unit #(
        .XLEN_PIXEL(8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .i      (i),
        .a      (a),
        .log_val(log_val),
        .diff   (diff),
        .neg    (neg),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_tab [13];

    initial begin
        exp_tab = '{16'h7FFF, 16'h00B1, 16'h004A, 16'h0022, 16'h0011, 16'h0008, 16'h0004,
                    16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};

        // Reset behaviour
        rst = 1'b1;
        i   = 5'd3;
        a   = 16'h0500;
        tick();
        tick();
        check("rst_log_val", 32'(log_val), 32'h0000);
        check("rst_diff", 32'(diff), 32'h0500);
        check("rst_neg", 32'(neg), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_log_val", 32'(log_val), 32'h0022);
        check("post_rst_diff", 32'(diff), 32'h04DE);

        // Table sweep, one index per cycle
        for (int k = 0; k <= 12; k++) begin
            i = 5'(k);
            tick();
            check($sformatf("sweep_log_val_i%0d", k), 32'(log_val), 32'(exp_tab[k]));
        end
        i = 5'd20;
        tick();
        check("sweep_log_val_i20", 32'(log_val), 32'h0000);
        i = 5'd31;
        tick();
        check("sweep_log_val_i31", 32'(log_val), 32'h0000);

        // Negative result
        a = 16'h0050;
        i = 5'd1;
        tick();
        check("neg_log_val", 32'(log_val), 32'h00B1);
        check("neg_diff", 32'(diff), 32'hFF9F);
        check("neg_neg", 32'(neg), 32'h1);
        check("neg_ovf", 32'(ovf), 32'h0);

        // Overflow
        a = 16'h8000;
        i = 5'd0;
        tick();
        check("ovf_log_val", 32'(log_val), 32'h7FFF);
        check("ovf_diff", 32'(diff), 32'h0001);
        check("ovf_neg", 32'(neg), 32'h0);
        check("ovf_ovf", 32'(ovf), 32'h1);

        // Latency: i change must wait for the next edge
        a = 16'h0100;
        i = 5'd2;
        tick();
        check("lat_diff_i2", 32'(diff), 32'h00B6);
        i = 5'd4;
        #1;
        check("lat_diff_hold", 32'(diff), 32'h00B6);
        tick();
        check("lat_diff_i4", 32'(diff), 32'h00EF);

        // Mid-sequence reset with index held
        i = 5'd5;
        tick();
        check("mid_log_val_a", 32'(log_val), 32'h0008);
        tick();
        check("mid_log_val_repeat", 32'(log_val), 32'h0008);
        rst = 1'b1;
        a   = 16'h8123;
        tick();
        check("mid_log_val_rst", 32'(log_val), 32'h0000);
        check("mid_diff_rst", 32'(diff), 32'h8123);
        check("mid_neg_rst", 32'(neg), 32'h1);
        check("mid_ovf_rst", 32'(ovf), 32'h0);
        rst = 1'b0;
        tick();
        check("mid_log_val_b", 32'(log_val), 32'h0008);
        check("mid_diff_b", 32'(diff), 32'h811B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
